render_cmd_sequencer: RTL and testbench

//  Command fetcher/decoder between the command queue and the Renderer.
//  - On i_process_start, pulls 12-byte draw commands from the queue, one byte per request.
//  - Latches the fields, starts the Renderer, waits for it to finish, then fetches the next command.
//  - Ends on an end-of-list command or queue EOF, then pulses o_process_done to the buffer controller.

---
 rtl/renderer_pkg.sv | 45 ++++
 rtl/render_cmd_regs.sv | 60 ++++++
 rtl/render_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_render_cmd_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renderer_pkg.sv
// Shared types and constants for the render command path: FSM states,
// draw-command byte layout and the decoded field record.
package renderer_pkg;

    localparam int CMD_BYTES   = 12;
    localparam int IDX_W       = 4;
    localparam int COORD_W     = 10;
    localparam int COLOR_W     = 4;
    localparam int CMD_END_BIT = 7;

    localparam logic [IDX_W-1:0] IDX_CMD  = 4'd0;
    localparam logic [IDX_W-1:0] IDX_X1   = 4'd1;
    localparam logic [IDX_W-1:0] IDX_Y1   = 4'd2;
    localparam logic [IDX_W-1:0] IDX_X2   = 4'd3;
    localparam logic [IDX_W-1:0] IDX_Y2   = 4'd4;
    localparam logic [IDX_W-1:0] IDX_HI   = 4'd5;
    localparam logic [IDX_W-1:0] IDX_RG   = 4'd6;
    localparam logic [IDX_W-1:0] IDX_BA   = 4'd7;
    localparam logic [IDX_W-1:0] IDX_TEX0 = 4'd8;
    localparam logic [IDX_W-1:0] IDX_TEX1 = 4'd9;
    localparam logic [IDX_W-1:0] IDX_TEX2 = 4'd10;
    localparam logic [IDX_W-1:0] IDX_TEX3 = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
        logic [COLOR_W-1:0] a;
        logic [31:0]        tex_base;
    } cmd_fields_t;

endpackage

// File: rtl/render_cmd_regs.sv
// Draw-command field registers: scatters one queue byte per strobe into the
// decoded rectangle, colour and texture fields according to its byte index.
module render_cmd_regs
    import renderer_pkg::*;
(
    input  logic              i_master_clk,
    input  logic              i_reset_n,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [7:0]        i_wr_data,
    output cmd_fields_t       o_fields
);

    cmd_fields_t fields_q, fields_d;

    // NOTE: fields_d starts as a copy of fields_q so every path assigns it; no latch.
    always_comb begin
        fields_d = fields_q;
        if (i_wr_en) begin
            unique case (i_wr_idx)
                IDX_X1:   fields_d.x1[7:0] = i_wr_data;
                IDX_Y1:   fields_d.y1[7:0] = i_wr_data;
                IDX_X2:   fields_d.x2[7:0] = i_wr_data;
                IDX_Y2:   fields_d.y2[7:0] = i_wr_data;
                IDX_HI: begin
                    fields_d.x1[9:8] = i_wr_data[1:0];
                    fields_d.y1[9:8] = i_wr_data[3:2];
                    fields_d.x2[9:8] = i_wr_data[5:4];
                    fields_d.y2[9:8] = i_wr_data[7:6];
                end
                IDX_RG: begin
                    fields_d.r = i_wr_data[3:0];
                    fields_d.g = i_wr_data[7:4];
                end
                IDX_BA: begin
                    fields_d.b = i_wr_data[3:0];
                    fields_d.a = i_wr_data[7:4];
                end
                IDX_TEX0: fields_d.tex_base[7:0]   = i_wr_data;
                IDX_TEX1: fields_d.tex_base[15:8]  = i_wr_data;
                IDX_TEX2: fields_d.tex_base[23:16] = i_wr_data;
                IDX_TEX3: fields_d.tex_base[31:24] = i_wr_data;
                // Opcode byte carries only the end-of-list flag the FSM consumes.
                default:  fields_d = fields_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignment so all registers update together.
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fields_q <= '0;
        end else begin
            fields_q <= fields_d;
        end
    end

    assign o_fields = fields_q;

endmodule

// File: rtl/render_cmd_sequencer.sv
// Command fetcher/decoder: pulls draw commands byte-by-byte from the command
// queue, starts the Renderer per command and reports end of list.
module render_cmd_sequencer #(
    parameter int CMD_BYTES   = renderer_pkg::CMD_BYTES,
    parameter int COORD_WIDTH = renderer_pkg::COORD_W,
    parameter int WATCHDOG_W  = 20
) (
    input  logic                   i_master_clk,
    input  logic                   i_reset_n,
    input  logic                   i_process_start,
    output logic                   o_process_done,
    output logic                   o_error,
    output logic                   o_busy,
    output logic                   o_queue_request,
    input  logic [7:0]             i_queue_data,
    input  logic                   i_queue_data_valid,
    input  logic                   i_queue_eof,
    output logic                   o_cmd_start,
    input  logic                   i_cmd_finished,
    output logic [COORD_WIDTH-1:0] o_cmd_rect_x1,
    output logic [COORD_WIDTH-1:0] o_cmd_rect_y1,
    output logic [COORD_WIDTH-1:0] o_cmd_rect_x2,
    output logic [COORD_WIDTH-1:0] o_cmd_rect_y2,
    output logic [3:0]             o_cmd_color_r,
    output logic [3:0]             o_cmd_color_g,
    output logic [3:0]             o_cmd_color_b,
    output logic [3:0]             o_cmd_color_a,
    output logic [31:0]            o_cmd_tex_base
);

    import renderer_pkg::*;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_BYTES - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   err_q, err_d;
    logic [WATCHDOG_W-1:0]  wd_q, wd_d;
    logic                   wd_expired;
    logic                   wr_en;
    cmd_fields_t            fields;

    assign wd_expired = &wd_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        wr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_process_start) begin
                    state_d = ST_REQ;
                    idx_d   = '0;
                end
            end
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                // A byte arriving together with eof wins; eof is only final when no byte came.
                if (i_queue_data_valid) begin
                    if (idx_q == IDX_CMD && i_queue_data[CMD_END_BIT]) begin
                        state_d = ST_DONE;
                    end else begin
                        wr_en = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_START;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_REQ;
                        end
                    end
                end else if (i_queue_eof) begin
                    state_d = ST_DONE;
                    err_d   = (idx_q != IDX_CMD);
                end else if (wd_expired) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (i_cmd_finished) begin
                    state_d = ST_REQ;
                    idx_d   = '0;
                end else if (wd_expired) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog restarts on every state change and saturates at all-ones.
        if (state_d != state_q) begin
            wd_d = '0;
        end else if ((state_q == ST_WAIT || state_q == ST_RUN) && !wd_expired) begin
            wd_d = wd_q + 1'b1;
        end else begin
            wd_d = wd_q;
        end
    end

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    render_cmd_regs u_regs (
        .i_master_clk (i_master_clk),
        .i_reset_n    (i_reset_n),
        .i_wr_en      (wr_en),
        .i_wr_idx     (idx_q),
        .i_wr_data    (i_queue_data),
        .o_fields     (fields)
    );

    assign o_busy          = (state_q != ST_IDLE);
    assign o_queue_request = (state_q == ST_REQ);
    assign o_cmd_start     = (state_q == ST_START);
    assign o_process_done  = (state_q == ST_DONE);
    assign o_error         = (state_q == ST_DONE) && err_q;

    assign o_cmd_rect_x1  = fields.x1;
    assign o_cmd_rect_y1  = fields.y1;
    assign o_cmd_rect_x2  = fields.x2;
    assign o_cmd_rect_y2  = fields.y2;
    assign o_cmd_color_r  = fields.r;
    assign o_cmd_color_g  = fields.g;
    assign o_cmd_color_b  = fields.b;
    assign o_cmd_color_a  = fields.a;
    assign o_cmd_tex_base = fields.tex_base;

endmodule

// File: tb/tb_render_cmd_sequencer.sv
// Scoreboard bench for render_cmd_sequencer: a queue responder and Renderer
// model drive the DUT; expected fields and done/error outcomes are queued.
module tb_render_cmd_sequencer;

    localparam int WD_W = 4;

    typedef struct {
        logic [9:0]  x1, y1, x2, y2;
        logic [3:0]  r, g, bb, a;
        logic [31:0] tex;
    } exp_fields_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        done, err, busy, q_req, cmd_start;
    logic [7:0]  q_data = '0;
    logic        q_valid = 1'b0;
    logic        q_eof = 1'b0;
    logic        fin = 1'b0;
    logic [9:0]  x1, y1, x2, y2;
    logic [3:0]  cr, cg, cb, ca;
    logic [31:0] tex;

    render_cmd_sequencer #(.WATCHDOG_W(WD_W)) dut (
        .i_master_clk       (clk),
        .i_reset_n          (rst_n),
        .i_process_start    (start),
        .o_process_done     (done),
        .o_error            (err),
        .o_busy             (busy),
        .o_queue_request    (q_req),
        .i_queue_data       (q_data),
        .i_queue_data_valid (q_valid),
        .i_queue_eof        (q_eof),
        .o_cmd_start        (cmd_start),
        .i_cmd_finished     (fin),
        .o_cmd_rect_x1      (x1),
        .o_cmd_rect_y1      (y1),
        .o_cmd_rect_x2      (x2),
        .o_cmd_rect_y2      (y2),
        .o_cmd_color_r      (cr),
        .o_cmd_color_g      (cg),
        .o_cmd_color_b      (cb),
        .o_cmd_color_a      (ca),
        .o_cmd_tex_base     (tex)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [8:0]  byte_q [$];       // {eof_with_byte, data}
    exp_fields_t exp_f_q [$];
    bit          exp_err_q [$];

    int  req_count = 0, start_count = 0, done_count = 0;
    int  req_at_start = 0, start_cyc = 0, done_cyc = 0;
    bit  fin_en = 1'b1;

    logic [7:0] cmd1 [12] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hE4,
                              8'hA5, 8'h3C, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] cmd2 [12] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h1B,
                              8'h96, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_fields_t decode(input logic [7:0] b [12]);
        exp_fields_t d;
        d.x1  = {b[5][1:0], b[1]};
        d.y1  = {b[5][3:2], b[2]};
        d.x2  = {b[5][5:4], b[3]};
        d.y2  = {b[5][7:6], b[4]};
        d.r   = b[6][3:0];
        d.g   = b[6][7:4];
        d.bb  = b[7][3:0];
        d.a   = b[7][7:4];
        d.tex = {b[11], b[10], b[9], b[8]};
        return d;
    endfunction

    // Queue up the first n bytes of a command; eof_idx marks a byte sent together with eof.
    task automatic push_cmd(input logic [7:0] b [12], input int n, input int eof_idx);
        for (int i = 0; i < n; i++) byte_q.push_back({(i == eof_idx), b[i]});
        if (n == 12) exp_f_q.push_back(decode(b));
    endtask

    always @(posedge clk) cyc++;

    // Queue model: answers each request 1..3 cycles later with a byte, or eof when empty.
    initial begin
        int pend = 0;
        forever begin
            @(negedge clk);
            q_valid = 1'b0;
            q_eof   = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (byte_q.size() > 0) begin
                        logic [8:0] e;
                        e = byte_q.pop_front();
                        q_data  = e[7:0];
                        q_valid = 1'b1;
                        q_eof   = e[8];
                    end else begin
                        q_eof = 1'b1;
                    end
                end
            end
            if (q_req && rst_n) pend = $urandom_range(1, 3);
        end
    end

    // Renderer model: finishes 3 cycles after each start unless withheld.
    initial forever begin
        @(negedge clk);
        if (cmd_start && fin_en) begin
            repeat (3) @(negedge clk);
            fin = 1'b1;
            @(negedge clk);
            fin = 1'b0;
        end
    end

    // Monitor: scoreboard pops on every start and done pulse.
    initial forever begin
        @(negedge clk);
        if (q_req) req_count++;
        if (cmd_start) begin
            start_count++;
            req_at_start = req_count;
            start_cyc    = cyc;
            check("start_expected", exp_f_q.size() > 0, 1);
            if (exp_f_q.size() > 0) begin
                exp_fields_t f;
                f = exp_f_q.pop_front();
                check("x1", x1, f.x1);
                check("y1", y1, f.y1);
                check("x2", x2, f.x2);
                check("y2", y2, f.y2);
                check("color_r", cr, f.r);
                check("color_g", cg, f.g);
                check("color_b", cb, f.bb);
                check("color_a", ca, f.a);
                check("tex_base", tex, f.tex);
            end
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
            check("done_expected", exp_err_q.size() > 0, 1);
            if (exp_err_q.size() > 0) check("done_error", err, exp_err_q.pop_front());
        end
        if (err && !done) check("error_without_done", err, 0);
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        int n = 0;
        while (done_count == base && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done_count"}, done_count - base, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req"}, q_req, 0);
        check({tag, "_start"}, cmd_start, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_fields"}, {x1, y1, x2, y2, cr, cg, cb, ca}, 0);
        check({tag, "_tex"}, tex, 0);
    endtask

    task automatic run_basic(input string tag);
        int rb, sb, db;
        rb = req_count; sb = start_count; db = done_count;
        push_cmd(cmd1, 12, -1);
        byte_q.push_back({1'b0, 8'h80});
        exp_err_q.push_back(1'b0);
        pulse_start();
        wait_done(db, 400, tag);
        check({tag, "_starts"}, start_count - sb, 1);
        check({tag, "_req_before_start"}, req_at_start - rb, 12);
        check({tag, "_req_total"}, req_count - rb, 13);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_sb_empty"}, exp_f_q.size() + exp_err_q.size(), 0);
    endtask

    initial begin
        int rb, sb, db;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: one command then end-of-list
        run_basic("t1");

        // 2: eof at index 0 is a clean end
        rb = req_count; sb = start_count; db = done_count;
        exp_err_q.push_back(1'b0);
        pulse_start();
        wait_done(db, 100, "t2");
        check("t2_starts", start_count - sb, 0);
        check("t2_req_total", req_count - rb, 1);

        // 3: eof at index 5 truncates the command
        sb = start_count; db = done_count;
        push_cmd(cmd2, 5, -1);
        exp_err_q.push_back(1'b1);
        pulse_start();
        wait_done(db, 200, "t3");
        check("t3_starts", start_count - sb, 0);
        check("t3_busy_after", busy, 0);

        // 4: Renderer never finishes, watchdog fires in RUN
        fin_en = 1'b0;
        sb = start_count; db = done_count;
        push_cmd(cmd2, 12, -1);
        exp_err_q.push_back(1'b1);
        pulse_start();
        wait_done(db, 400, "t4");
        check("t4_starts", start_count - sb, 1);
        check("t4_run_cycles", done_cyc - start_cyc, (1 << WD_W) + 1);
        fin_en = 1'b1;

        // 5: valid with eof at index 3 keeps fetching
        rb = req_count; sb = start_count; db = done_count;
        push_cmd(cmd2, 12, 3);
        byte_q.push_back({1'b0, 8'h80});
        exp_err_q.push_back(1'b0);
        pulse_start();
        wait_done(db, 400, "t5");
        check("t5_starts", start_count - sb, 1);
        check("t5_req_total", req_count - rb, 13);

        // 6: reset while in RUN
        fin_en = 1'b0;
        sb = start_count; db = done_count;
        push_cmd(cmd1, 12, -1);
        pulse_start();
        begin
            int n = 0;
            while (start_count == sb && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("t6_started", start_count - sb, 1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("t6_async");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("t6_no_done", done_count - db, 0);
        fin_en = 1'b1;
        repeat (2) @(negedge clk);

        run_basic("t6_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
